branch_resolver: RTL and testbench

- Pipelined successor to the single-cycle branch evaluator in the reference CPU.
- Accepts a stream of fetched instructions with PC and operand values over a valid/ready handshake and decodes the full MIPS branch/jump set, including link variants.
- Tracks the architectural delay slot: a taken branch's redirect is emitted together with the delay-slot instruction that follows it.
- Sits between operand read and the PC-update logic; also keeps saturating branch statistics.

---
 rtl/branch_resolver.sv | 211 +++++++++++++++++++++
 tb/tb_branch_resolver.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_resolver.sv
`default_nettype none
// ============================================================================
//  Module      : branch_resolver
//  Description : Pipelined MIPS branch/jump resolver with delay-slot tracking,
//                link generation and saturating branch statistics.
//  Revision    : 1.0  initial release
// ============================================================================
module branch_resolver #(
    parameter int DATA_WIDTH = 32,
    parameter int TAG_WIDTH  = 4,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [31:0]           in_instr,
    input  logic [DATA_WIDTH-1:0] in_pc,
    input  logic [DATA_WIDTH-1:0] in_rs_val,
    input  logic [DATA_WIDTH-1:0] in_rt_val,
    input  logic [TAG_WIDTH-1:0]  in_tag,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [TAG_WIDTH-1:0]  out_tag,
    output logic                  out_is_branch,
    output logic                  out_taken,
    output logic                  out_redirect,
    output logic [DATA_WIDTH-1:0] out_target,
    output logic                  out_link_we,
    output logic [4:0]            out_link_reg,
    output logic [DATA_WIDTH-1:0] out_link_val,
    output logic                  out_slot_err,
    output logic [CNT_WIDTH-1:0]  cnt_branch,
    output logic [CNT_WIDTH-1:0]  cnt_taken
);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_SLOT = 1'b1
    } state_t;

    state_t                r_state;
    logic [DATA_WIDTH-1:0] r_pend_target;
    logic                  r_out_valid;
    logic [TAG_WIDTH-1:0]  r_out_tag;
    logic                  r_out_is_branch;
    logic                  r_out_taken;
    logic                  r_out_redirect;
    logic [DATA_WIDTH-1:0] r_out_target;
    logic                  r_out_link_we;
    logic [4:0]            r_out_link_reg;
    logic [DATA_WIDTH-1:0] r_out_link_val;
    logic                  r_out_slot_err;
    logic [CNT_WIDTH-1:0]  r_cnt_branch;
    logic [CNT_WIDTH-1:0]  r_cnt_taken;

    logic [5:0]            w_op;
    logic [4:0]            w_rt;
    logic [4:0]            w_rd;
    logic [5:0]            w_funct;
    logic                  w_unused_shamt;
    logic [DATA_WIDTH-1:0] w_seq_pc;
    logic [DATA_WIDTH-1:0] w_br_target;
    logic [DATA_WIDTH-1:0] w_j_target;
    logic                  w_rs_neg;
    logic                  w_rs_zero;
    logic                  w_is_br;
    logic                  w_cond;
    logic [DATA_WIDTH-1:0] w_target;
    logic                  w_link;
    logic [4:0]            w_link_reg;
    logic                  w_in_xfer;
    logic                  w_in_slot;
    logic                  w_slot_err;
    logic                  w_eff_taken;
    logic                  w_eff_link;

    assign w_op           = in_instr[31:26];
    assign w_rt           = in_instr[20:16];
    assign w_rd           = in_instr[15:11];
    assign w_funct        = in_instr[5:0];
    assign w_unused_shamt = ^in_instr[10:6];

    assign w_seq_pc    = in_pc + DATA_WIDTH'(4);
    assign w_br_target = w_seq_pc + {{(DATA_WIDTH-18){in_instr[15]}}, in_instr[15:0], 2'b00};
    // Jump keeps the upper bits of pc+4 above bit 27 and replaces the rest.
    assign w_j_target  = (w_seq_pc & ~DATA_WIDTH'(28'hFFF_FFFF))
                       | DATA_WIDTH'({in_instr[25:0], 2'b00});
    assign w_rs_neg    = in_rs_val[DATA_WIDTH-1];
    assign w_rs_zero   = (in_rs_val == '0);

    // Decode the branch class, its condition, target and link destination.
    always_comb begin
        w_is_br    = 1'b0;
        w_cond     = 1'b0;
        w_target   = '0;
        w_link     = 1'b0;
        w_link_reg = 5'd0;
        case (w_op)
            6'h04: begin w_is_br = 1'b1; w_cond = (in_rs_val == in_rt_val); w_target = w_br_target; end
            6'h05: begin w_is_br = 1'b1; w_cond = (in_rs_val != in_rt_val); w_target = w_br_target; end
            6'h06: begin w_is_br = 1'b1; w_cond = w_rs_neg || w_rs_zero;    w_target = w_br_target; end
            6'h07: begin w_is_br = 1'b1; w_cond = !w_rs_neg && !w_rs_zero;  w_target = w_br_target; end
            6'h01: begin
                case (w_rt)
                    5'h00: begin w_is_br = 1'b1; w_cond = w_rs_neg;  w_target = w_br_target; end
                    5'h01: begin w_is_br = 1'b1; w_cond = !w_rs_neg; w_target = w_br_target; end
                    5'h10: begin
                        w_is_br = 1'b1; w_cond = w_rs_neg;  w_target = w_br_target;
                        w_link  = 1'b1; w_link_reg = 5'd31;
                    end
                    5'h11: begin
                        w_is_br = 1'b1; w_cond = !w_rs_neg; w_target = w_br_target;
                        w_link  = 1'b1; w_link_reg = 5'd31;
                    end
                    default: ;
                endcase
            end
            6'h02: begin w_is_br = 1'b1; w_cond = 1'b1; w_target = w_j_target; end
            6'h03: begin
                w_is_br = 1'b1; w_cond = 1'b1; w_target = w_j_target;
                w_link  = 1'b1; w_link_reg = 5'd31;
            end
            6'h00: begin
                if (w_funct == 6'h08) begin
                    w_is_br = 1'b1; w_cond = 1'b1; w_target = in_rs_val;
                end else if (w_funct == 6'h09) begin
                    w_is_br = 1'b1; w_cond = 1'b1; w_target = in_rs_val;
                    w_link  = 1'b1; w_link_reg = w_rd;
                end
            end
            default: ;
        endcase
    end

    assign in_ready    = !r_out_valid || out_ready;
    assign w_in_xfer   = in_valid && in_ready;
    assign w_in_slot   = (r_state == S_SLOT);
    // A branch sitting in a delay slot is flagged and neutralised.
    assign w_slot_err  = w_in_slot && w_is_br;
    assign w_eff_taken = w_cond && w_is_br && !w_slot_err;
    assign w_eff_link  = w_link && !w_slot_err;

    // Delay-slot FSM and output staging register.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state         <= S_IDLE;
            r_pend_target   <= '0;
            r_out_valid     <= 1'b0;
            r_out_tag       <= '0;
            r_out_is_branch <= 1'b0;
            r_out_taken     <= 1'b0;
            r_out_redirect  <= 1'b0;
            r_out_target    <= '0;
            r_out_link_we   <= 1'b0;
            r_out_link_reg  <= 5'd0;
            r_out_link_val  <= '0;
            r_out_slot_err  <= 1'b0;
        end else if (flush) begin
            r_state       <= S_IDLE;
            r_pend_target <= '0;
            r_out_valid   <= 1'b0;
        end else if (w_in_xfer) begin
            r_out_valid     <= 1'b1;
            r_out_tag       <= in_tag;
            r_out_is_branch <= w_is_br;
            r_out_taken     <= w_eff_taken;
            r_out_redirect  <= w_in_slot;
            r_out_target    <= w_in_slot ? r_pend_target : '0;
            r_out_link_we   <= w_eff_link;
            r_out_link_reg  <= w_eff_link ? w_link_reg : 5'd0;
            r_out_link_val  <= in_pc + DATA_WIDTH'(8);
            r_out_slot_err  <= w_slot_err;
            if (w_in_slot) begin
                r_state <= S_IDLE;
            end else if (w_eff_taken) begin
                r_state       <= S_SLOT;
                r_pend_target <= w_target;
            end
        end else if (r_out_valid && out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    // Saturating statistics on accepted, non-flushed branches.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_cnt_branch <= '0;
            r_cnt_taken  <= '0;
        end else if (!flush && w_in_xfer && w_is_br && !w_slot_err) begin
            if (r_cnt_branch != '1) r_cnt_branch <= r_cnt_branch + CNT_WIDTH'(1);
            if (w_eff_taken && (r_cnt_taken != '1)) r_cnt_taken <= r_cnt_taken + CNT_WIDTH'(1);
        end
    end

    assign out_valid     = r_out_valid;
    assign out_tag       = r_out_tag;
    assign out_is_branch = r_out_is_branch;
    assign out_taken     = r_out_taken;
    assign out_redirect  = r_out_redirect;
    assign out_target    = r_out_target;
    assign out_link_we   = r_out_link_we;
    assign out_link_reg  = r_out_link_reg;
    assign out_link_val  = r_out_link_val;
    assign out_slot_err  = r_out_slot_err;
    assign cnt_branch    = r_cnt_branch;
    assign cnt_taken     = r_cnt_taken;

endmodule
`default_nettype wire

// File: tb/tb_branch_resolver.sv
`default_nettype none
// ============================================================================
//  Module      : tb_branch_resolver
//  Description : Directed self-checking bench for branch_resolver with an
//                architectural reference model compared on every cycle.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_branch_resolver;

    logic        clk = 1'b0;
    logic        resetn, flush, in_valid, in_ready, out_valid, out_ready;
    logic [31:0] in_instr, in_pc, in_rs_val, in_rt_val;
    logic [3:0]  in_tag, out_tag;
    logic        out_is_branch, out_taken, out_redirect, out_link_we, out_slot_err;
    logic [31:0] out_target, out_link_val;
    logic [4:0]  out_link_reg;
    logic [15:0] cnt_branch, cnt_taken;

    int errors = 0;
    int checks = 0;
    logic [3:0] tagc = 4'd0;

    localparam logic [31:0] ADDU = 32'h0022_1821;

    branch_resolver #(.DATA_WIDTH(32), .TAG_WIDTH(4), .CNT_WIDTH(16)) dut (
        .clk(clk), .resetn(resetn), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
        .in_pc(in_pc), .in_rs_val(in_rs_val), .in_rt_val(in_rt_val), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready), .out_tag(out_tag),
        .out_is_branch(out_is_branch), .out_taken(out_taken), .out_redirect(out_redirect),
        .out_target(out_target), .out_link_we(out_link_we), .out_link_reg(out_link_reg),
        .out_link_val(out_link_val), .out_slot_err(out_slot_err),
        .cnt_branch(cnt_branch), .cnt_taken(cnt_taken)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    typedef struct {
        bit          br;
        bit          tk;
        logic [31:0] tgt;
        bit          lwe;
        logic [4:0]  lreg;
    } dec_t;

    // Architectural meaning of one instruction, straight from the ISA rules.
    function automatic dec_t decode(input logic [31:0] ins, input logic [31:0] pc,
                                    input logic [31:0] rs, input logic [31:0] rt);
        dec_t d;
        logic [31:0] seq, bt, jt;
        int srs;
        seq = pc + 32'd4;
        bt  = seq + ($signed({{16{ins[15]}}, ins[15:0]}) * 4);
        jt  = {seq[31:28], ins[25:0], 2'b00};
        srs = $signed(rs);
        d = '{br: 0, tk: 0, tgt: 32'd0, lwe: 0, lreg: 5'd0};
        case (ins[31:26])
            6'd4: d = '{1, rs == rt, bt, 0, 5'd0};
            6'd5: d = '{1, rs != rt, bt, 0, 5'd0};
            6'd6: d = '{1, srs <= 0, bt, 0, 5'd0};
            6'd7: d = '{1, srs > 0,  bt, 0, 5'd0};
            6'd1: begin
                if (ins[20:16] == 5'd0)  d = '{1, srs < 0,  bt, 0, 5'd0};
                if (ins[20:16] == 5'd1)  d = '{1, srs >= 0, bt, 0, 5'd0};
                if (ins[20:16] == 5'd16) d = '{1, srs < 0,  bt, 1, 5'd31};
                if (ins[20:16] == 5'd17) d = '{1, srs >= 0, bt, 1, 5'd31};
            end
            6'd2: d = '{1, 1, jt, 0, 5'd0};
            6'd3: d = '{1, 1, jt, 1, 5'd31};
            6'd0: begin
                if (ins[5:0] == 6'd8) d = '{1, 1, rs, 0, 5'd0};
                if (ins[5:0] == 6'd9) d = '{1, 1, rs, 1, ins[15:11]};
            end
            default: ;
        endcase
        return d;
    endfunction

    // Reference model state: what the output stage and counters must hold.
    bit          m_valid, m_slot, m_br, m_tk, m_redir, m_lwe, m_serr;
    logic [31:0] m_pend, m_tgt, m_lval;
    logic [3:0]  m_tag;
    logic [4:0]  m_lreg;
    int          m_cb, m_ct;

    // Advance the model on each edge, then compare the DUT to it.
    always @(posedge clk) begin : model
        dec_t d;
        bit rdy, xfer, serr;
        if (!resetn) begin
            m_valid = 0; m_slot = 0; m_pend = 0; m_cb = 0; m_ct = 0;
        end else begin
            rdy  = !m_valid || out_ready;
            xfer = in_valid && rdy;
            if (flush) begin
                m_valid = 0; m_slot = 0;
            end else if (xfer) begin
                d       = decode(in_instr, in_pc, in_rs_val, in_rt_val);
                serr    = m_slot && d.br;
                m_valid = 1;
                m_tag   = in_tag;
                m_br    = d.br;
                m_tk    = d.tk && !serr;
                m_redir = m_slot;
                m_tgt   = m_pend;
                m_lwe   = d.lwe && !serr;
                m_lreg  = d.lreg;
                m_lval  = in_pc + 32'd8;
                m_serr  = serr;
                if (d.br && !serr) begin
                    if (m_cb < 65535) m_cb++;
                    if (m_tk && m_ct < 65535) m_ct++;
                end
                if (m_slot) m_slot = 0;
                else if (m_tk) begin m_slot = 1; m_pend = d.tgt; end
            end else if (m_valid && out_ready) begin
                m_valid = 0;
            end
        end
        #1;
        chk("in_ready", in_ready, !m_valid || out_ready);
        chk("out_valid", out_valid, m_valid);
        chk("cnt_branch", cnt_branch, m_cb);
        chk("cnt_taken", cnt_taken, m_ct);
        if (m_valid) begin
            chk("tag", out_tag, m_tag);
            chk("is_branch", out_is_branch, m_br);
            chk("taken", out_taken, m_tk);
            chk("redirect", out_redirect, m_redir);
            chk("slot_err", out_slot_err, m_serr);
            chk("link_we", out_link_we, m_lwe);
            chk("link_val", out_link_val, m_lval);
            if (m_redir) chk("target", out_target, m_tgt);
            if (m_lwe)   chk("link_reg", out_link_reg, m_lreg);
        end
    end

    task automatic drive(input logic [31:0] ins, input logic [31:0] pc,
                         input logic [31:0] rs, input logic [31:0] rt);
        in_valid = 1'b1; in_instr = ins; in_pc = pc;
        in_rs_val = rs; in_rt_val = rt; in_tag = tagc; tagc = tagc + 4'd1;
    endtask

    task automatic send(input logic [31:0] ins, input logic [31:0] pc,
                        input logic [31:0] rs, input logic [31:0] rt);
        @(negedge clk);
        drive(ins, pc, rs, rt);
        @(posedge clk); #2;
        in_valid = 1'b0;
    endtask

    logic [31:0] misc_ins [9] = '{32'h1820_0003, 32'h1C20_0003, 32'h0420_0005, 32'h0421_0005,
                                  32'h0430_0002, 32'h0C00_0040, 32'h0020_0008, 32'h8C22_0000,
                                  32'h0422_0000};
    logic [31:0] misc_rs  [9] = '{32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFB, 32'h0,
                                  32'h1, 32'h0, 32'h0000_7000, 32'h0, 32'h0};

    initial begin
        resetn = 1'b0; flush = 1'b0; out_ready = 1'b1;
        drive(32'h1022_0004, 32'h0, 32'h0, 32'h0);
        repeat (3) @(posedge clk);
        #2;
        chk("rst_valid", out_valid, 1'b0);
        chk("rst_cnt_branch", cnt_branch, 16'd0);
        chk("rst_redirect", out_redirect, 1'b0);
        chk("rst_target", out_target, 32'd0);
        @(negedge clk); resetn = 1'b1; in_valid = 1'b0;

        // Taken BEQ then its delay slot.
        send(32'h1022_0004, 32'h0000_1000, 32'd5, 32'd5);
        chk("beq_taken", out_taken, 1'b1);
        chk("beq_redirect", out_redirect, 1'b0);
        send(ADDU, 32'h0000_1004, 32'd1, 32'd2);
        chk("beq_slot_redirect", out_redirect, 1'b1);
        chk("beq_slot_target", out_target, 32'h0000_1014);
        chk("beq_cnt_branch", cnt_branch, 16'd1);
        chk("beq_cnt_taken", cnt_taken, 16'd1);

        // Not-taken BNE: no slot.
        send(32'h1422_0010, 32'h0000_1100, 32'd7, 32'd7);
        chk("bne_taken", out_taken, 1'b0);
        send(ADDU, 32'h0000_1104, 32'd1, 32'd2);
        chk("bne_next_redirect", out_redirect, 1'b0);
        chk("bne_cnt_taken", cnt_taken, 16'd1);

        // BGEZAL not taken still links.
        send(32'h0431_0008, 32'h0000_2000, 32'h8000_0000, 32'd0);
        chk("bgezal_taken", out_taken, 1'b0);
        chk("bgezal_link_we", out_link_we, 1'b1);
        chk("bgezal_link_reg", out_link_reg, 5'd31);
        chk("bgezal_link_val", out_link_val, 32'h0000_2008);

        // JALR then a stalled delay slot.
        send(32'h0020_2009, 32'h0000_3100, 32'h0000_3000, 32'd0);
        chk("jalr_taken", out_taken, 1'b1);
        chk("jalr_link_reg", out_link_reg, 5'd4);
        @(negedge clk);
        out_ready = 1'b0;
        drive(ADDU, 32'h0000_3104, 32'd1, 32'd2);
        repeat (3) begin
            @(posedge clk); #2;
            chk("stall_valid", out_valid, 1'b1);
            chk("stall_in_ready", in_ready, 1'b0);
            chk("stall_link_reg", out_link_reg, 5'd4);
        end
        @(negedge clk); out_ready = 1'b1;
        @(posedge clk); #2; in_valid = 1'b0;
        chk("jalr_slot_redirect", out_redirect, 1'b1);
        chk("jalr_slot_target", out_target, 32'h0000_3000);

        // J in the delay slot of a taken BEQ.
        send(32'h1022_0010, 32'h0000_4000, 32'd3, 32'd3);
        send(32'h0800_0100, 32'h0000_4004, 32'd0, 32'd0);
        chk("slot_err", out_slot_err, 1'b1);
        chk("slot_err_taken", out_taken, 1'b0);
        chk("slot_err_target", out_target, 32'h0000_4044);
        chk("slot_err_cnt", cnt_branch, 16'd5);

        // J outside a slot.
        send(32'h0800_0100, 32'h0000_5000, 32'd0, 32'd0);
        send(ADDU, 32'h0000_5004, 32'd1, 32'd2);
        chk("j_target", out_target, 32'h0000_0400);

        // Flush while in SLOT, with a coinciding input that is dropped.
        send(32'h1022_0004, 32'h0000_6000, 32'd9, 32'd9);
        @(negedge clk);
        flush = 1'b1;
        drive(32'h1422_0010, 32'h0000_6004, 32'd1, 32'd2);
        @(posedge clk); #2;
        chk("flush_valid", out_valid, 1'b0);
        chk("flush_cnt", cnt_branch, 16'd7);
        @(negedge clk); flush = 1'b0; in_valid = 1'b0;
        send(ADDU, 32'h0000_6008, 32'd1, 32'd2);
        chk("flush_no_redirect", out_redirect, 1'b0);

        // Assorted branch classes, each followed by a plain instruction.
        for (int i = 0; i < 9; i++) begin
            send(misc_ins[i], 32'h0000_7000 + 32'(i * 8), misc_rs[i], 32'd0);
            send(ADDU, 32'h0000_7004 + 32'(i * 8), 32'd1, 32'd2);
        end

        // Saturation of the branch counter.
        @(negedge clk);
        drive(32'h1422_0010, 32'h0000_8000, 32'd0, 32'd0);
        repeat (65535) @(posedge clk);
        #2; in_valid = 1'b0;
        chk("sat_cnt", cnt_branch, 16'hFFFF);
        send(32'h1422_0010, 32'h0000_9000, 32'd0, 32'd0);
        chk("sat_hold", cnt_branch, 16'hFFFF);

        repeat (2) @(posedge clk);
        #3;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
